// File: rtl/updown_sequencer_pkg.sv
// Shared constants and types for the up/down counter control front-end.
// State and direction encodings stay plain 1-bit constants so older code that compares raw bits keeps working.
package updown_sequencer_pkg;

  localparam logic ST_STOP  = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int TICK_DIV_DEF  = 50_000_000;
  localparam int DB_CYCLES_DEF = 500_000;

  // One-cycle press pulses, one per debounced button.
  typedef struct packed {
    logic run;
    logic dir;
    logic step;
    logic clr;
  } btn_press_t;

endpackage

// File: rtl/updown_sequencer_btn_debounce.sv
// Button input conditioner: 2-FF synchronizer, stability-counter debouncer and rising-edge press pulse.
// Raw press to press pulse takes 2 + DB_CYCLES + 1 cycles.
module btn_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // NOTE: all state is assigned with <= so every register samples pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/updown_sequencer.sv
// STOP/RUN sequencer for the 4-bit up/down counter: debounced buttons in,
// registered STEP/CLR strobes and DIR/RUNNING levels out.
module updown_sequencer
  import updown_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RUN,
  input  logic BTN_DIR,
  input  logic BTN_STEP,
  input  logic BTN_CLR,
  output logic STEP,
  output logic DIR,
  output logic CLR,
  output logic RUNNING
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  btn_press_t    press;
  logic          state,   state_n;
  logic [PW-1:0] presc,   presc_n;
  logic          step_r,  step_n;
  logic          dir_r,   dir_n;
  logic          clr_r,   clr_n;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run  (.CLK(CLK), .RESET(RESET), .btn(BTN_RUN),  .press(press.run));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir  (.CLK(CLK), .RESET(RESET), .btn(BTN_DIR),  .press(press.dir));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (.CLK(CLK), .RESET(RESET), .btn(BTN_STEP), .press(press.step));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr  (.CLK(CLK), .RESET(RESET), .btn(BTN_CLR),  .press(press.clr));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    presc_n = presc;
    step_n  = 1'b0;
    dir_n   = press.dir ? ~dir_r : dir_r;
    clr_n   = press.clr;

    if (press.run) begin
      // A run press wins over both a manual step and a due auto-step.
      state_n = (state == ST_STOP) ? ST_RUN : ST_STOP;
      presc_n = '0;
    end else if (state == ST_RUN) begin
      if (presc == PRESC_LAST) begin
        presc_n = '0;
        step_n  = 1'b1;
      end else begin
        presc_n = presc + 1'b1;
      end
    end else begin
      step_n = press.step;
    end

    if (press.clr) begin
      step_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_STOP;
      presc  <= '0;
      step_r <= 1'b0;
      dir_r  <= DIR_UP;
      clr_r  <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      step_r <= step_n;
      dir_r  <= dir_n;
      clr_r  <= clr_n;
    end
  end

  assign STEP    = step_r;
  assign DIR     = dir_r;
  assign CLR     = clr_r;
  assign RUNNING = (state == ST_RUN);

endmodule

// File: tb/tb_updown_sequencer.sv
// Scoreboard bench for updown_sequencer with TICK_DIV=4, DB_CYCLES=3.
// Stimulus pushes expected STEP/CLR pulses; a monitor pops and compares each pulse the DUT emits.
module tb_updown_sequencer;

  localparam int B_RUN  = 0;
  localparam int B_DIR  = 1;
  localparam int B_STEP = 2;
  localparam int B_CLR  = 3;
  localparam int LAT    = 7;  // raw press -> output change: 2 sync + 3 debounce + 1 edge + 1 output reg

  typedef struct {
    bit is_clr;
    bit dir;
    int at;
  } exp_t;

  logic CLK;
  logic RESET;
  logic [3:0] btn;
  logic STEP, DIR, CLR, RUNNING;

  int   cyc;
  int   rel [4];
  int   passed;
  int   total;
  exp_t q[$];

  updown_sequencer #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTN_RUN(btn[B_RUN]), .BTN_DIR(btn[B_DIR]), .BTN_STEP(btn[B_STEP]), .BTN_CLR(btn[B_CLR]),
    .STEP(STEP), .DIR(DIR), .CLR(CLR), .RUNNING(RUNNING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    rel[idx] = cyc + 4;
  endtask

  task automatic push_exp(input bit is_clr, input bit d, input int at);
    exp_t e;
    e.is_clr = is_clr;
    e.dir    = d;
    e.at     = at;
    q.push_back(e);
  endtask

  // Auto-release of pressed buttons after their hold time.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++)
      if (btn[i] && cyc >= rel[i]) btn[i] = 1'b0;
  end

  // Monitor: every STEP or CLR pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (STEP || CLR) begin
      check("step_clr_exclusive", int'(STEP && CLR), 0);
      if (q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind_clr", int'(CLR), int'(e.is_clr));
        check("pulse_cycle", cyc, e.at);
        check("pulse_dir", int'(DIR), int'(e.dir));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, c;
    passed = 0;
    total  = 0;
    for (int i = 0; i < 4; i++) rel[i] = 1_000_000;
    RESET = 1'b1;
    btn   = 4'hF;

    // 1: reset with all buttons held
    @(negedge CLK);
    @(negedge CLK);
    check("reset_step", int'(STEP), 0);
    check("reset_clr", int'(CLR), 0);
    check("reset_dir", int'(DIR), 1);
    check("reset_running", int'(RUNNING), 0);
    RESET = 1'b0;
    btn   = 4'h0;
    wait_until(cyc + 10);
    check("idle_running", int'(RUNNING), 0);

    // 2: bouncing step button, then a stable press
    b = cyc;
    for (int k = 0; k < 6; k++) begin
      wait_until(b + 2 * k);
      btn[B_STEP] = (k % 2 == 0);
    end
    wait_until(b + 12);
    btn[B_STEP] = 1'b1;
    push_exp(1'b0, 1'b1, b + 12 + LAT);
    wait_until(b + 22);
    btn[B_STEP] = 1'b0;
    wait_until(b + 35);

    // 3: run rate, manual step ignored in RUN, stop
    b = cyc;
    r = b + LAT;
    press(B_RUN);
    for (int k = 1; k <= 5; k++) push_exp(1'b0, 1'b1, r + 4 * k);
    wait_until(b + 6);
    check("run_not_yet", int'(RUNNING), 0);
    wait_until(b + 7);
    check("run_entered", int'(RUNNING), 1);
    wait_until(b + 10);
    press(B_STEP);
    wait_until(b + 22);
    press(B_RUN);
    wait_until(b + 28);
    check("run_still", int'(RUNNING), 1);
    wait_until(b + 29);
    check("run_stopped", int'(RUNNING), 0);
    wait_until(b + 45);

    // 4 + 5a: direction toggles in RUN, CLR colliding with a due auto-step
    b = cyc;
    r = b + LAT;
    press(B_RUN);
    push_exp(1'b0, 1'b1, r + 4);
    push_exp(1'b0, 1'b1, r + 8);
    push_exp(1'b0, 1'b0, r + 12);
    push_exp(1'b0, 1'b0, r + 16);
    push_exp(1'b0, 1'b1, r + 20);
    push_exp(1'b0, 1'b1, r + 24);
    push_exp(1'b1, 1'b1, r + 28);
    push_exp(1'b0, 1'b1, r + 32);
    wait_until(b + 7);
    check("run2_entered", int'(RUNNING), 1);
    wait_until(b + 9);
    press(B_DIR);
    wait_until(b + 15);
    check("dir_before_toggle", int'(DIR), 1);
    wait_until(b + 16);
    check("dir_toggled_down", int'(DIR), 0);
    wait_until(b + 17);
    press(B_DIR);
    wait_until(b + 23);
    check("dir_still_down", int'(DIR), 0);
    wait_until(b + 24);
    check("dir_toggled_up", int'(DIR), 1);
    wait_until(b + 28);
    press(B_CLR);
    wait_until(b + 34);
    press(B_RUN);
    wait_until(b + 40);
    check("run2_still", int'(RUNNING), 1);
    wait_until(b + 41);
    check("run2_stopped", int'(RUNNING), 0);
    wait_until(b + 50);

    // 5b + 6: run+step+dir together in STOP, then reset on a due step
    b = cyc;
    r = b + LAT;
    press(B_RUN);
    press(B_STEP);
    press(B_DIR);
    push_exp(1'b0, 1'b0, r + 4);
    wait_until(r);
    check("collide_running", int'(RUNNING), 1);
    check("collide_no_step", int'(STEP), 0);
    check("collide_dir", int'(DIR), 0);
    wait_until(r + 7);
    RESET = 1'b1;
    wait_until(r + 8);
    check("midrun_reset_step", int'(STEP), 0);
    check("midrun_reset_running", int'(RUNNING), 0);
    check("midrun_reset_dir", int'(DIR), 1);
    check("midrun_reset_clr", int'(CLR), 0);
    RESET = 1'b0;
    wait_until(r + 24);
    check("post_reset_stopped", int'(RUNNING), 0);
    c = cyc;
    press(B_RUN);
    push_exp(1'b0, 1'b1, c + LAT + 4);
    wait_until(c + LAT);
    check("rerun_entered", int'(RUNNING), 1);
    wait_until(c + LAT + 7);

    check("missing_pulses", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
